// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for the execute-stage ALU.
// The producer/consumer side uses master; the ALU uses slave.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifts.
// Define ALU_MUL_EN to add an iterative shift-add multiplier on 1010.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  alu_exec_unit_if.slave io
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {K_SLL, K_SRL, K_MUL} kind_e;

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod;
`endif

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.result    = result_q;
  assign io.zero      = zero_q;
  assign io.illegal   = illegal_q;

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    sc_res    = '0;
    sc_ill    = 1'b0;
`ifdef ALU_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          state_d = DONE;
          case (io.alu_ctrl)
            4'b0000: sc_res = io.op_a & io.op_b;
            4'b0001: sc_res = io.op_a | io.op_b;
            4'b0010: sc_res = io.op_a + io.op_b;
            4'b0110: sc_res = io.op_a - io.op_b;
            4'b0111: sc_res = WIDTH'($signed(io.op_a) < $signed(io.op_b));
            4'b1100: sc_res = ~(io.op_a | io.op_b);
            4'b1000, 4'b1001: begin
              state_d = BUSY;
              kind_d  = io.alu_ctrl[0] ? K_SRL : K_SLL;
              acc_d   = io.op_a;
              cnt_d   = io.op_b[SW-1:0];
            end
`ifdef ALU_MUL_EN
            4'b1010: begin
              state_d  = BUSY;
              kind_d   = K_MUL;
              acc_d    = '0;
              mcand_d  = io.op_a;
              mplier_d = io.op_b;
              cnt_d    = SW'(WIDTH - 1);
            end
`endif
            default: sc_ill = 1'b1;
          endcase
          if (state_d == DONE) begin
            result_d  = sc_res;
            zero_d    = (sc_res == '0);
            illegal_d = sc_ill;
          end
        end
      end
      BUSY: begin
`ifdef ALU_MUL_EN
        if (kind_q == K_MUL) begin
          prod     = acc_q + (mplier_q[0] ? mcand_q : '0);
          acc_d    = prod;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == '0) begin
            state_d   = DONE;
            result_d  = prod;
            zero_d    = (prod == '0);
            illegal_d = 1'b0;
          end else begin
            cnt_d = cnt_q - SW'(1);
          end
        end else
`endif
        if (cnt_q == '0) begin
          state_d   = DONE;
          result_d  = acc_q;
          zero_d    = (acc_q == '0);
          illegal_d = 1'b0;
        end else begin
          acc_d = (kind_q == K_SRL) ? (acc_q >> 1) : (acc_q << 1);
          cnt_d = cnt_q - SW'(1);
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      kind_q    <= K_SLL;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with a behavioural model.
// Build with ALU_MUL_EN defined to exercise the multiplier expectations.
module tb_alu_exec_unit;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         il;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   tot_cnt = 0;
  bit   exp_live = 1'b0;
  exp_t exp_cur;

  alu_exec_unit_if #(.WIDTH(W)) io ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  // Reference: outputs and latency (negedges from accept to out_valid)
  function automatic exp_t model(input logic [3:0] c,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int   sh;
    sh    = int'(b % W);
    e.res = '0;
    e.il  = 1'b0;
    e.lat = 1;
    case (c)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = a + b;
      4'd6:  e.res = a - b;
      4'd7:  e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd12: e.res = ~(a | b);
      4'd8:  begin e.res = a << sh; e.lat = sh + 2; end
      4'd9:  begin e.res = a >> sh; e.lat = sh + 2; end
`ifdef ALU_MUL_EN
      4'd10: begin e.res = W'(a * b); e.lat = W + 1; end
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && io.out_valid) begin
      if (!exp_live) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("result", io.result, exp_cur.res);
        chk("zero", W'(io.zero), W'(exp_cur.z));
        chk("illegal", W'(io.illegal), W'(exp_cur.il));
        chk("in_ready_in_done", W'(io.in_ready), 0);
      end
    end
  end

  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold,
                       input bit noise, input bit lit_en,
                       input logic [W-1:0] lr, input bit lz,
                       input bit li);
    exp_t         e;
    int           n;
    logic [W-1:0] held;
    e = model(c, a, b);
    @(negedge clk);
    chk("in_ready_idle", W'(io.in_ready), 1);
    io.in_valid = 1'b1;
    io.alu_ctrl = c;
    io.op_a     = a;
    io.op_b     = b;
    @(posedge clk);
    #1;
    exp_cur  = e;
    exp_live = 1'b1;
    if (noise) begin
      io.alu_ctrl  = 4'b0010;
      io.op_a      = $urandom;
      io.op_b      = $urandom;
      io.out_ready = 1'b1;
    end else begin
      io.in_valid = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!io.out_valid && n < 200);
    io.in_valid = 1'b0;
    if (!io.out_valid) begin
      chk("timeout_out_valid", 0, 1);
    end else begin
      chk("latency", W'(n), W'(e.lat));
      if (lit_en) begin
        chk("lit_result", io.result, lr);
        chk("lit_zero", W'(io.zero), W'(lz));
        chk("lit_illegal", W'(io.illegal), W'(li));
      end
    end
    held = io.result;
    io.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_result", io.result, held);
      chk("hold_out_valid", W'(io.out_valid), 1);
    end
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    exp_live     = 1'b0;
    chk("idle_in_ready", W'(io.in_ready), 1);
    chk("idle_out_valid", W'(io.out_valid), 0);
  endtask

  initial begin
    bit seen;
    io.in_valid  = 1'b0;
    io.alu_ctrl  = '0;
    io.op_a      = '0;
    io.op_b      = '0;
    io.out_ready = 1'b0;
    #3;
    chk("rst_in_ready", W'(io.in_ready), 1);
    chk("rst_out_valid", W'(io.out_valid), 0);
    chk("rst_result", io.result, 0);
    chk("rst_zero", W'(io.zero), 0);
    chk("rst_illegal", W'(io.illegal), 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 32'h0, 1, 0);
    do_op(4'b0110, 32'd5, 32'd7, 0, 0, 1, 32'hFFFF_FFFE, 0, 0);
    do_op(4'b0111, 32'hFFFF_FFFE, 32'd1, 0, 0, 1, 32'd1, 0, 0);
    do_op(4'b0111, 32'd5, 32'd3, 0, 0, 1, 32'd0, 1, 0);
    do_op(4'b0111, 32'd9, 32'd9, 0, 0, 0, 0, 0, 0);
    do_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 1, 32'h00F0_1200, 0, 0);
    do_op(4'b0001, 32'hA000_0005, 32'h0500_0050, 0, 0, 1, 32'hA500_0055, 0, 0);
    do_op(4'b1100, 32'hFFFF_0000, 32'h0000_FFF0, 0, 0, 1, 32'h0000_000F, 0, 0);
    do_op(4'b1000, 32'd1, 32'd31, 0, 0, 1, 32'h8000_0000, 0, 0);
    do_op(4'b1001, 32'hDEAD_BEEF, 32'd0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    do_op(4'b1001, 32'h8000_0000, 32'h0000_0024, 0, 0, 1, 32'h0800_0000, 0, 0);
    do_op(4'b1000, 32'h0000_00F1, 32'd4, 0, 1, 1, 32'h0000_0F10, 0, 0);
    do_op(4'b0011, 32'd1, 32'd2, 0, 0, 1, 32'h0, 1, 1);
`ifdef ALU_MUL_EN
    do_op(4'b1010, 32'd3, 32'd7, 0, 0, 1, 32'd21, 0, 0);
    do_op(4'b1010, 32'hFFFF_FFFF, 32'd3, 0, 0, 1, 32'hFFFF_FFFD, 0, 0);
`else
    do_op(4'b1010, 32'd3, 32'd7, 0, 0, 1, 32'h0, 1, 1);
`endif
    do_op(4'b0001, 32'h0000_1000, 32'h0000_0001, 10, 0, 1, 32'h0000_1001, 0, 0);
    do_op(4'b0010, 32'd40, 32'd2, 0, 1, 1, 32'd42, 0, 0);

    // Reset in the middle of a long shift must discard it
    @(negedge clk);
    io.in_valid = 1'b1;
    io.alu_ctrl = 4'b1000;
    io.op_a     = 32'h1234_5678;
    io.op_b     = 32'd20;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_shift_busy", W'(io.in_ready), 0);
    rst = 1'b1;
    #1;
    chk("arst_in_ready", W'(io.in_ready), 1);
    chk("arst_out_valid", W'(io.out_valid), 0);
    chk("arst_result", io.result, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (io.out_valid) seen = 1'b1;
    end
    chk("no_result_after_rst", W'(seen), 0);
    chk("post_rst_in_ready", W'(io.in_ready), 1);
    chk("post_rst_result", io.result, 0);

    do_op(4'b0110, 32'd100, 32'd1, 0, 0, 1, 32'd99, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
